// File: rtl/alu_mem_cmd_master.sv
// Command master for the ALU/register-file slave: writes operands and opcode,
// verifies the opcode by readback, starts the operation and returns the result.
module alu_mem_cmd_master #(
  parameter int ADDR_WIDTH  = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int RES_WIDTH   = 16,
  parameter int RES_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  input  logic [DATA_WIDTH-1:0] cmd_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [RES_WIDTH-1:0]  rsp_res,
  output logic                  rsp_err,
  output logic [7:0]            err_count,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_wr,
  output logic                  enable,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic [RES_WIDTH-1:0]  res_out
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_A, S_WR_B, S_WR_OP, S_RD_OP, S_CHK, S_START, S_WAIT, S_RESP
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_A     = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_B     = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_OP    = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL  = ADDR_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] CTRL_START = DATA_WIDTH'(1);
  // Counter value seen during the final WAIT cycle.
  localparam logic [3:0]            WAIT_LAST  = 4'(RES_LATENCY - 1);

  state_t                  state_r;
  logic [DATA_WIDTH-1:0]   a_r;
  logic [DATA_WIDTH-1:0]   b_r;
  logic [DATA_WIDTH-1:0]   op_r;
  logic [3:0]              wait_cnt_r;
  logic [RES_WIDTH-1:0]    rsp_res_r;
  logic                    rsp_err_r;
  logic [7:0]              err_cnt_r;

  // Sequencer: command latch, bus phase progression, result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      a_r        <= '0;
      b_r        <= '0;
      op_r       <= '0;
      wait_cnt_r <= 4'd0;
      rsp_res_r  <= '0;
      rsp_err_r  <= 1'b0;
      err_cnt_r  <= 8'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (cmd_valid) begin
            a_r     <= cmd_a;
            b_r     <= cmd_b;
            op_r    <= cmd_op;
            state_r <= S_WR_A;
          end
        end
        S_WR_A:  state_r <= S_WR_B;
        S_WR_B:  state_r <= S_WR_OP;
        S_WR_OP: state_r <= S_RD_OP;
        S_RD_OP: state_r <= S_CHK;
        S_CHK: begin
          if (rd_data == op_r) begin
            state_r <= S_START;
          end else begin
            rsp_res_r <= '0;
            rsp_err_r <= 1'b1;
            if (err_cnt_r != 8'hFF) begin
              err_cnt_r <= err_cnt_r + 8'd1;
            end
            state_r <= S_RESP;
          end
        end
        S_START: begin
          wait_cnt_r <= 4'd0;
          state_r    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt_r == WAIT_LAST) begin
            rsp_res_r <= res_out;
            rsp_err_r <= 1'b0;
            state_r   <= S_RESP;
          end else begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_r <= S_IDLE;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // Moore bus decode from the state register and latched command.
  always_comb begin
    enable  = 1'b0;
    rd_wr   = 1'b0;
    addr    = '0;
    wr_data = '0;
    case (state_r)
      S_WR_A: begin
        enable  = 1'b1;
        addr    = ADDR_A;
        wr_data = a_r;
      end
      S_WR_B: begin
        enable  = 1'b1;
        addr    = ADDR_B;
        wr_data = b_r;
      end
      S_WR_OP: begin
        enable  = 1'b1;
        addr    = ADDR_OP;
        wr_data = op_r;
      end
      S_RD_OP: begin
        enable = 1'b1;
        rd_wr  = 1'b1;
        addr   = ADDR_OP;
      end
      S_START: begin
        enable  = 1'b1;
        addr    = ADDR_CTRL;
        wr_data = CTRL_START;
      end
      default: begin
        enable  = 1'b0;
        rd_wr   = 1'b0;
        addr    = '0;
        wr_data = '0;
      end
    endcase
  end

  assign cmd_ready = (state_r == S_IDLE) && reset;
  assign rsp_valid = (state_r == S_RESP);
  assign rsp_res   = rsp_res_r;
  assign rsp_err   = rsp_err_r;
  assign err_count = err_cnt_r;

endmodule

// File: doc/alu_mem_cmd_master.md
Name: alu_mem_cmd_master

Overview:
Upstream command master for the ALU/register-file slave. It accepts one compute command (operand A, operand B, opcode) on a valid/ready request channel and runs it on the slave bus:
- writes A, B and the opcode into the slave registers;
- reads the opcode back to check it;
- writes the start register, waits a fixed latency, then captures the 16-bit result.
The result is returned on a valid/ready response channel. The master is the only driver of the slave bus.

Parameters:
ADDR_WIDTH, 2, slave address width
DATA_WIDTH, 8, operand/opcode/bus data width
RES_WIDTH, 16, slave result width
RES_LATENCY, 2, cycles from the start-write cycle to a stable res_out; legal range 1..15

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
cmd_valid  input  1  command request
cmd_ready  output  1  master can accept a command
cmd_a  input  DATA_WIDTH  operand A
cmd_b  input  DATA_WIDTH  operand B
cmd_op  input  DATA_WIDTH  opcode
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_res  output  RES_WIDTH  captured result
rsp_err  output  1  opcode readback mismatch
err_count  output  8  saturating count of mismatches
addr  output  ADDR_WIDTH  slave address
wr_data  output  DATA_WIDTH  slave write data
rd_wr  output  1  0 = write, 1 = read
enable  output  1  slave access strobe
rd_data  input  DATA_WIDTH  slave read data
res_out  input  RES_WIDTH  slave result

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (reset=0).
- Reset values: state IDLE; cmd_ready=0 while reset=0; rsp_valid, rsp_res, rsp_err, err_count, addr, wr_data, rd_wr, enable all 0.
- Slave register map: 0 = A, 1 = B, 2 = opcode, 3 = control. Writing 8'h01 to address 3 starts the operation.
- Slave read timing: rd_data is valid in the cycle after an enable=1, rd_wr=1 cycle.
- Bus outputs and cmd_ready/rsp_valid are Moore outputs, decoded from the state register only. In any state not listed below: enable=0, addr=0, wr_data=0, rd_wr=0.
- cmd_ready = (state==IDLE) and reset=1.
- FSM states, with the handshake cycle as N:
  - IDLE: on cmd_valid & cmd_ready, latch cmd_a/cmd_b/cmd_op, then go to WR_A.
  - WR_A (N+1): enable=1, rd_wr=0, addr=0, wr_data=A. Next: WR_B.
  - WR_B (N+2): addr=1, wr_data=B. Next: WR_OP.
  - WR_OP (N+3): addr=2, wr_data=op. Next: RD_OP.
  - RD_OP (N+4): enable=1, rd_wr=1, addr=2, wr_data=0. Next: CHK.
  - CHK (N+5): enable=0; compare rd_data with the latched op.
    - Equal: next START.
    - Different: rsp_err<=1, rsp_res<=0, err_count+1 (saturate at 255), next RESP.
  - START (N+6): enable=1, rd_wr=0, addr=3, wr_data=8'h01. Clears a 4-bit wait counter. Next: WAIT.
  - WAIT: lasts exactly RES_LATENCY cycles. On the clock edge ending the last WAIT cycle: rsp_res<=res_out, rsp_err<=0. Next: RESP.
  - RESP: rsp_valid=1. rsp_res and rsp_err are held stable until rsp_ready=1, then go to IDLE.
- Latency from command handshake to first rsp_valid cycle:
  - Success: N+7+RES_LATENCY (N+9 at default).
  - Mismatch: N+6.
- Back-to-back commands: next cmd_ready is high in the cycle after the response handshake. Minimum issue interval is 8+RES_LATENCY cycles.
- Commands cannot be accepted while busy. cmd_valid held during busy is simply not acknowledged.
- rsp_ready may be held high permanently; RESP then lasts one cycle.
- Reset asserted in any state aborts immediately (asynchronously): bus outputs go to 0, no response is produced, and the latched command is discarded. err_count is also cleared by reset.
- res_out and rd_data are ignored outside the CHK and final-WAIT sample points.

Test Plan:
1. Hold reset=0 for 3 cycles, then release -> all outputs 0 during reset; cmd_ready=1 in the first cycle after release; enable stays 0.
2. Command A=8'h12, B=8'h34, op=8'h01; slave returns rd_data=8'h01 in CHK; res_out=16'h0046 -> exact cycle sequence:
   - bus: (addr0, 8'h12) at N+1, (addr1, 8'h34) at N+2, (addr2, 8'h01) at N+3, read addr2 at N+4, (addr3, 8'h01) at N+6;
   - response: rsp_valid at N+9 with rsp_res=16'h0046, rsp_err=0.
3. Same command but rd_data=8'h03 in CHK -> no address-3 write; rsp_valid at N+6 with rsp_err=1, rsp_res=0; err_count=1.
4. Hold rsp_ready=0 for 5 cycles in RESP with cmd_valid=1 pending -> rsp_res/rsp_err stable and cmd_ready=0 throughout. On the rsp handshake the FSM goes to IDLE; cmd_ready=1 in the next cycle and the pending command is accepted then.
5. Assert reset during the first WAIT cycle -> enable/addr/wr_data go to 0 without a clock edge; no rsp_valid; after release, a fresh command completes normally per scenario 2.
6. 260 consecutive mismatch commands -> err_count increments to 255 and stays at 255; each response still has rsp_err=1.
